fifo_burst_reader: RTL and testbench

- Read-side master for the team's single-clock synchronous FIFO.
- On a start command it pops a programmed number of words through the FIFO's read-enable/empty/read-data interface and presents them downstream as a valid/ready stream.
- Output is registered through a 2-entry skid buffer, giving full throughput under backpressure with no combinational ready-to-rden path.
- Sits between any FIFO instance and a stream consumer (packetiser, serialiser, bus writer).

---
 rtl/fifo_burst_pkg.sv | 14 +
 rtl/stream_skid_buf.sv | 101 ++++++++++
 rtl/fifo_burst_reader.sv | 114 +++++++++++
 tb/tb_fifo_burst_reader.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_pkg.sv
// Shared types and constants for the FIFO burst reader and its output skid buffer.
package fifo_burst_pkg;

    // Burst controller states
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Skid buffer occupancy width (0..2 entries)
    localparam int unsigned OCC_W = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready skid buffer. The head register drives the output; the
// skid register catches a word that arrives while the head is still held.
module stream_skid_buf
    import fifo_burst_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              head_last_q, head_last_d;
    logic              skid_last_q, skid_last_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              accept;

    assign accept = (occ_q != '0) & out_ready;

    // Next-state: place the incoming word and advance the skid into the head on accept
    always_comb begin
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        occ_d       = occ_q;
        if (flush) begin
            head_data_d = '0;
            head_last_d = 1'b0;
            skid_data_d = '0;
            skid_last_d = 1'b0;
            occ_d       = '0;
        end else begin
            unique case ({in_valid, accept})
                2'b10: begin
                    if (occ_q == '0) begin
                        head_data_d = in_data;
                        head_last_d = in_last;
                    end else begin
                        skid_data_d = in_data;
                        skid_last_d = in_last;
                    end
                    occ_d = occ_q + OCC_W'(1);
                end
                2'b01: begin
                    if (occ_q == OCC_W'(2)) begin
                        head_data_d = skid_data_q;
                        head_last_d = skid_last_q;
                    end
                    occ_d = occ_q - OCC_W'(1);
                end
                2'b11: begin
                    // Upstream never pushes at occ=2; the skid branch only keeps order if it did
                    if (occ_q == OCC_W'(2)) begin
                        head_data_d = skid_data_q;
                        head_last_d = skid_last_q;
                        skid_data_d = in_data;
                        skid_last_d = in_last;
                    end else begin
                        head_data_d = in_data;
                        head_last_d = in_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_data_q <= '0;
            head_last_q <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            occ_q       <= '0;
        end else begin
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            occ_q       <= occ_d;
        end
    end

    assign out_valid = (occ_q != '0);
    assign out_data  = head_data_q;
    assign out_last  = head_last_q & out_valid;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst master: pops a programmed number of words from a synchronous
// FIFO and presents them as a valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fifo_rden,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_rddata,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready
);

    state_e           state_q;
    logic [LEN_W-1:0] pop_cnt_q;
    logic [LEN_W-1:0] out_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [OCC_W-1:0] occ;
    logic             accept;
    logic             flush;
    logic             pop_last;

    assign accept   = o_valid & i_ready;
    assign flush    = (state_q == StRun) & i_abort;
    // Popped word is the burst's final one when it is the last pop outstanding
    assign pop_last = (pop_cnt_q == LEN_W'(1));

    // Pop only while room remains in the buffer, so ready never reaches rden combinationally
    assign o_fifo_rden = (state_q == StRun) & ~i_abort & (pop_cnt_q != '0) &
                         ~i_fifo_empty & (occ < OCC_W'(2));

    // Burst FSM with its counters and registered status outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            pop_cnt_q <= '0;
            out_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start && (i_len != '0)) begin
                        state_q   <= StRun;
                        pop_cnt_q <= i_len;
                        out_cnt_q <= i_len;
                        busy_q    <= 1'b1;
                    end
                end
                StRun: begin
                    if (i_abort) begin
                        state_q   <= StIdle;
                        pop_cnt_q <= '0;
                        out_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        if (o_fifo_rden) begin
                            pop_cnt_q <= pop_cnt_q - LEN_W'(1);
                        end
                        if (accept) begin
                            out_cnt_q <= out_cnt_q - LEN_W'(1);
                            if (out_cnt_q == LEN_W'(1)) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;

    stream_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (o_fifo_rden),
        .in_data   (i_fifo_rddata),
        .in_last   (pop_last),
        .out_valid (o_valid),
        .out_data  (o_data),
        .out_last  (o_last),
        .out_ready (i_ready),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a FIFO model feeds the DUT; a queue of pushed
// words predicts the stream each burst must produce.
module tb_fifo_burst_reader;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              i_start = 1'b0;
    logic [LEN_W-1:0]  i_len = '0;
    logic              i_abort = 1'b0;
    logic              i_ready = 1'b0;
    logic              o_busy, o_done, o_fifo_rden, o_valid, o_last;
    logic [DATA_W-1:0] o_data;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rddata;

    always #5 clk = ~clk;

    // FIFO model: head word visible combinationally, pop and push on the edge
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = '0;
    logic [7:0] rd_ptr = '0;
    logic [7:0] fifo_cnt;
    logic       push_en = 1'b0;
    logic [7:0] push_data = '0;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_rddata = mem[rd_ptr];
    assign fifo_cnt    = wr_ptr - rd_ptr;

    always @(posedge clk) begin
        if (o_fifo_rden && !fifo_empty) rd_ptr <= rd_ptr + 8'd1;
        if (push_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 8'd1;
        end
    end

    fifo_burst_reader #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_start       (i_start),
        .i_len         (i_len),
        .i_abort       (i_abort),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_fifo_rden   (o_fifo_rden),
        .i_fifo_empty  (fifo_empty),
        .i_fifo_rddata (fifo_rddata),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_last        (o_last),
        .i_ready       (i_ready)
    );

    // Observation log, sampled at the active edge
    int         cyc = 0;
    logic [8:0] got_q [$];
    int         got_cyc [$];
    int         pop_cyc [$];
    int         done_cyc [$];
    int         n_bad_rden = 0;
    int         n_unstable = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rstn) begin
            if (o_fifo_rden) pop_cyc.push_back(cyc);
            if (o_fifo_rden && fifo_empty) n_bad_rden <= n_bad_rden + 1;
            if (o_valid && i_ready) begin
                got_q.push_back({o_last, o_data});
                got_cyc.push_back(cyc);
            end
            if (o_done) done_cyc.push_back(cyc);
            if (prev_stall && o_valid && ({o_last, o_data} !== prev_word))
                n_unstable <= n_unstable + 1;
            prev_stall <= o_valid && !i_ready;
            prev_word  <= {o_last, o_data};
        end else begin
            prev_stall <= 1'b0;
        end
    end

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] model_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        push_en   = 1'b1;
        push_data = d;
        model_q.push_back(d);
        tick();
        push_en = 1'b0;
    endtask

    task automatic start_burst(input logic [7:0] n);
        i_start = 1'b1;
        i_len   = n;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int k = 0;
        while (o_busy && k < budget) begin
            tick();
            k++;
        end
        ok = !o_busy;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #2;
        n_checks++;
        if ({o_busy, o_done, o_fifo_rden, o_valid, o_last} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {o_busy, o_done, o_fifo_rden, o_valid, o_last});
        else n_pass++;
        n_checks++;
        if (o_data !== 8'h00) $display("FAIL reset_data: got %h want 00", o_data);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        tick();
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL reset_idle: got %b want 0", o_busy);
        else n_pass++;
    endtask

    task automatic test_streaming();
        int p0, g0, d0; bit ok; logic [8:0] e;
        for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
        i_ready = 1'b1;
        p0 = pop_cyc.size(); g0 = got_q.size(); d0 = done_cyc.size();
        start_burst(8'd4);
        wait_idle(40, ok);
        n_checks++;
        if (!ok) $display("FAIL stream_timeout: busy %b want 0", o_busy); else n_pass++;
        n_checks++;
        if (pop_cyc.size() - p0 != 4)
            $display("FAIL stream_pops: got %0d want 4", pop_cyc.size() - p0);
        else n_pass++;
        n_checks++;
        if (got_q.size() - g0 != 4)
            $display("FAIL stream_count: got %0d want 4", got_q.size() - g0);
        else n_pass++;
        for (int i = 0; i < 4 && g0 + i < got_q.size(); i++) begin
            e = {(i == 3), model_q[i]};
            n_checks++;
            if (got_q[g0 + i] !== e)
                $display("FAIL stream_word%0d: got %h want %h", i, got_q[g0 + i], e);
            else n_pass++;
        end
        if (got_q.size() - g0 == 4 && pop_cyc.size() - p0 == 4) begin
            n_checks++;
            if (got_cyc[g0] != pop_cyc[p0] + 1 || got_cyc[g0 + 3] != got_cyc[g0] + 3)
                $display("FAIL stream_timing: first acc %0d last acc %0d first pop %0d",
                         got_cyc[g0], got_cyc[g0 + 3], pop_cyc[p0]);
            else n_pass++;
        end
        n_checks++;
        if (done_cyc.size() - d0 != 1 || done_cyc[done_cyc.size() - 1] != got_cyc[got_q.size() - 1] + 1)
            $display("FAIL stream_done: pulses %0d want 1 one cycle after last word",
                     done_cyc.size() - d0);
        else n_pass++;
        repeat (4) void'(model_q.pop_front());
    endtask

    task automatic test_backpressure();
        int p0, g0, k, bad_hold; bit ok; logic [8:0] e;
        for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
        i_ready = 1'b0;
        p0 = pop_cyc.size(); g0 = got_q.size();
        start_burst(8'd4);
        k = 0;
        while (!o_valid && k < 10) begin tick(); k++; end
        bad_hold = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_valid !== 1'b1 || o_data !== 8'h11) bad_hold++;
            tick();
        end
        n_checks++;
        if (bad_hold != 0) $display("FAIL bp_hold: %0d cycles off, want 0 (data 11)", bad_hold);
        else n_pass++;
        n_checks++;
        if (pop_cyc.size() - p0 != 2)
            $display("FAIL bp_pops: got %0d want 2", pop_cyc.size() - p0);
        else n_pass++;
        n_checks++;
        if (o_fifo_rden !== 1'b0) $display("FAIL bp_rden_low: got %b want 0", o_fifo_rden);
        else n_pass++;
        i_ready = 1'b1;
        wait_idle(40, ok);
        n_checks++;
        if (!ok || got_q.size() - g0 != 4)
            $display("FAIL bp_count: got %0d want 4", got_q.size() - g0);
        else n_pass++;
        for (int i = 0; i < 4 && g0 + i < got_q.size(); i++) begin
            e = {(i == 3), model_q[i]};
            n_checks++;
            if (got_q[g0 + i] !== e)
                $display("FAIL bp_word%0d: got %h want %h", i, got_q[g0 + i], e);
            else n_pass++;
        end
        n_checks++;
        if (n_unstable != 0) $display("FAIL bp_stable: got %0d changes want 0", n_unstable);
        else n_pass++;
        repeat (4) void'(model_q.pop_front());
    endtask

    task automatic test_underrun();
        int g0, d0, b0, early; logic [8:0] e;
        logic [7:0] w [3];
        w[0] = 8'hA0; w[1] = 8'hA1; w[2] = 8'hA2;
        i_ready = 1'b1;
        g0 = got_q.size(); d0 = done_cyc.size(); b0 = n_bad_rden;
        start_burst(8'd3);
        early = 0;
        for (int t = 1; t <= 20; t++) begin
            push_en = 1'b0;
            if (t == 5)  begin push_en = 1'b1; push_data = w[0]; end
            if (t == 9)  begin push_en = 1'b1; push_data = w[1]; end
            if (t == 10) begin push_en = 1'b1; push_data = w[2]; end
            if (push_en) model_q.push_back(push_data);
            if (t <= 5 && o_valid) early++;
            tick();
        end
        push_en = 1'b0;
        n_checks++;
        if (n_bad_rden != b0) $display("FAIL ur_rden_empty: got %0d want 0", n_bad_rden - b0);
        else n_pass++;
        n_checks++;
        if (early != 0) $display("FAIL ur_early_valid: got %0d want 0", early);
        else n_pass++;
        n_checks++;
        if (got_q.size() - g0 != 3) $display("FAIL ur_count: got %0d want 3", got_q.size() - g0);
        else n_pass++;
        for (int i = 0; i < 3 && g0 + i < got_q.size(); i++) begin
            e = {(i == 2), model_q[i]};
            n_checks++;
            if (got_q[g0 + i] !== e)
                $display("FAIL ur_word%0d: got %h want %h", i, got_q[g0 + i], e);
            else n_pass++;
        end
        n_checks++;
        if (done_cyc.size() - d0 != 1 || o_busy !== 1'b0)
            $display("FAIL ur_done: pulses %0d busy %b want 1 and 0", done_cyc.size() - d0, o_busy);
        else n_pass++;
        repeat (3) void'(model_q.pop_front());
    endtask

    task automatic test_cmd_edges();
        int p0, g0, d0; bit ok; logic [8:0] e;
        p0 = pop_cyc.size(); d0 = done_cyc.size();
        start_burst(8'd0);
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL len0_busy: got %b want 0", o_busy); else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (pop_cyc.size() != p0 || done_cyc.size() != d0)
            $display("FAIL len0_quiet: pops %0d dones %0d want 0 0",
                     pop_cyc.size() - p0, done_cyc.size() - d0);
        else n_pass++;
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        i_ready = 1'b1;
        p0 = pop_cyc.size(); g0 = got_q.size(); d0 = done_cyc.size();
        start_burst(8'd3);
        start_burst(8'd5);
        wait_idle(40, ok);
        n_checks++;
        if (!ok || pop_cyc.size() - p0 != 3)
            $display("FAIL restart_pops: got %0d want 3", pop_cyc.size() - p0);
        else n_pass++;
        n_checks++;
        if (done_cyc.size() - d0 != 1 || fifo_cnt !== 8'd2)
            $display("FAIL restart_left: dones %0d fifo %0d want 1 2", done_cyc.size() - d0, fifo_cnt);
        else n_pass++;
        for (int i = 0; i < 3 && g0 + i < got_q.size(); i++) begin
            e = {(i == 2), model_q[i]};
            n_checks++;
            if (got_q[g0 + i] !== e)
                $display("FAIL restart_word%0d: got %h want %h", i, got_q[g0 + i], e);
            else n_pass++;
        end
        repeat (3) void'(model_q.pop_front());
        start_burst(8'd2);
        wait_idle(40, ok);
        repeat (2) void'(model_q.pop_front());
    endtask

    task automatic test_abort();
        int p0, g0, d0, k, pops, left; bit ok; logic [8:0] e;
        for (int i = 0; i < 8; i++) push(8'($urandom));
        i_ready = 1'b1;
        p0 = pop_cyc.size(); g0 = got_q.size(); d0 = done_cyc.size();
        start_burst(8'd8);
        k = 0;
        while (got_q.size() - g0 < 3 && k < 30) begin tick(); k++; end
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0)
            $display("FAIL abort_idle: busy %b valid %b want 0 0", o_busy, o_valid);
        else n_pass++;
        repeat (3) tick();
        pops = pop_cyc.size() - p0;
        n_checks++;
        if (done_cyc.size() != d0) $display("FAIL abort_no_done: got %0d want 0", done_cyc.size() - d0);
        else n_pass++;
        n_checks++;
        if (int'(fifo_cnt) != 8 - pops)
            $display("FAIL abort_fifo_cnt: got %0d want %0d", fifo_cnt, 8 - pops);
        else n_pass++;
        for (int i = 0; i < 3 && g0 + i < got_q.size(); i++) begin
            e = {1'b0, model_q[i]};
            n_checks++;
            if (got_q[g0 + i] !== e)
                $display("FAIL abort_word%0d: got %h want %h", i, got_q[g0 + i], e);
            else n_pass++;
        end
        repeat (pops) void'(model_q.pop_front());
        left = 8 - pops;
        g0 = got_q.size();
        start_burst(8'(left));
        wait_idle(40, ok);
        n_checks++;
        if (!ok || got_q.size() - g0 != left)
            $display("FAIL abort_drain_count: got %0d want %0d", got_q.size() - g0, left);
        else n_pass++;
        for (int i = 0; i < left && g0 + i < got_q.size(); i++) begin
            e = {(i == left - 1), model_q[i]};
            n_checks++;
            if (got_q[g0 + i] !== e)
                $display("FAIL abort_drain%0d: got %h want %h", i, got_q[g0 + i], e);
            else n_pass++;
        end
        repeat (left) void'(model_q.pop_front());
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            int n, pre, pushed, p0, g0, d0, k, bad;
            logic [8:0] e;
            n = $urandom_range(1, 24);
            pre = $urandom_range(0, n);
            for (int i = 0; i < pre; i++) push(8'($urandom));
            pushed = pre;
            p0 = pop_cyc.size(); g0 = got_q.size(); d0 = done_cyc.size();
            i_ready = ($urandom_range(0, 1) == 1);
            start_burst(8'(n));
            k = 0;
            while ((o_busy || pushed < n) && k < 500) begin
                i_ready = ($urandom_range(0, 3) != 0);
                push_en = 1'b0;
                if (pushed < n && $urandom_range(0, 1) == 1) begin
                    push_en   = 1'b1;
                    push_data = 8'($urandom);
                    model_q.push_back(push_data);
                    pushed++;
                end
                tick();
                k++;
            end
            push_en = 1'b0;
            i_ready = 1'b1;
            n_checks++;
            if (o_busy || got_q.size() - g0 != n || pop_cyc.size() - p0 != n)
                $display("FAIL rand%0d_count: words %0d pops %0d want %0d",
                         b, got_q.size() - g0, pop_cyc.size() - p0, n);
            else n_pass++;
            bad = 0;
            for (int i = 0; i < n && g0 + i < got_q.size(); i++) begin
                e = {(i == n - 1), model_q[i]};
                if (got_q[g0 + i] !== e) bad++;
            end
            n_checks++;
            if (bad != 0) $display("FAIL rand%0d_words: %0d wrong of %0d", b, bad, n);
            else n_pass++;
            n_checks++;
            if (done_cyc.size() - d0 != 1)
                $display("FAIL rand%0d_done: got %0d want 1", b, done_cyc.size() - d0);
            else n_pass++;
            repeat (n) void'(model_q.pop_front());
        end
        n_checks++;
        if (n_unstable != 0 || n_bad_rden != 0)
            $display("FAIL rand_protocol: unstable %0d rden_empty %0d want 0 0", n_unstable, n_bad_rden);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int p0, g0, k, pops, left; bit ok; logic [8:0] e;
        for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
        i_ready = 1'b0;
        p0 = pop_cyc.size();
        start_burst(8'd4);
        k = 0;
        while (!o_valid && k < 10) begin tick(); k++; end
        tick();
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_busy, o_fifo_rden} !== 3'b000)
            $display("FAIL areset_outputs: got %b want 000", {o_valid, o_busy, o_fifo_rden});
        else n_pass++;
        @(posedge clk);
        #1 rstn = 1'b1;
        pops = pop_cyc.size() - p0;
        repeat (pops) void'(model_q.pop_front());
        left = 4 - pops;
        i_ready = 1'b1;
        g0 = got_q.size();
        start_burst(8'(left));
        wait_idle(40, ok);
        n_checks++;
        if (!ok || got_q.size() - g0 != left)
            $display("FAIL areset_drain: got %0d want %0d", got_q.size() - g0, left);
        else n_pass++;
        for (int i = 0; i < left && g0 + i < got_q.size(); i++) begin
            e = {(i == left - 1), model_q[i]};
            n_checks++;
            if (got_q[g0 + i] !== e)
                $display("FAIL areset_word%0d: got %h want %h", i, got_q[g0 + i], e);
            else n_pass++;
        end
        repeat (left) void'(model_q.pop_front());
        test_streaming();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_underrun();
        test_cmd_edges();
        test_abort();
        test_random();
        test_async_reset();
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
